// File: rtl/sprite_plotter.sv
// sprite_plotter: walks a WIDTH x HEIGHT bitmap held in an external
// synchronous ROM and emits one pixel per clock (x, y, colour, plot) for the
// VGA adapter write port. The image is placed at a run-time origin, and
// pixels that land off the visible screen are clipped (plot=0).
//
// Optional feature macro: SPRITE_TRANSPARENT_EN
//   defined   -> pixels whose ROM colour equals TRANSPARENT are not plotted
//   undefined -> every on-screen pixel is plotted
//
// Handshake: start is sampled only while busy=0. It is accepted in IDLE,
// including the cycle in which done pulses, giving back-to-back plots.
// busy stays high from the first address cycle until the pipeline has
// drained. done is a one-cycle pulse that follows the last pixel slot.
module sprite_plotter #(
   parameter int WIDTH       = 320,
   parameter int HEIGHT      = 240,
   parameter int ADDR_W      = 17,
   parameter int COLOUR_W    = 6,
   parameter int ROM_LATENCY = 1,
   parameter int SCREEN_W    = 320,
   parameter int SCREEN_H    = 240,
   parameter logic [COLOUR_W-1:0] TRANSPARENT = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [8:0]          x_origin,
   input  logic [7:0]          y_origin,
   output logic [ADDR_W-1:0]   rom_address,
   input  logic [COLOUR_W-1:0] rom_q,
   output logic [8:0]          x,
   output logic [7:0]          y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done,
   output logic [1:0]          dbg_state
);

   // Index of the final stage of the coordinate delay line.
   localparam int LAST = ROM_LATENCY - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              r_state;
   logic [8:0]          r_col;
   logic [7:0]          r_row;
   logic [ADDR_W-1:0]   r_rom_address;
   logic [8:0]          r_x_org;
   logic [7:0]          r_y_org;
   logic [1:0]          r_drain_cnt;
   logic                r_busy;
   logic                r_done;

   // Coordinate/valid delay line, aligned with the ROM read latency.
   logic [ROM_LATENCY-1:0] r_pv;
   logic [8:0]             r_pcol [ROM_LATENCY];
   logic [7:0]             r_prow [ROM_LATENCY];

   // Output pixel registers.
   logic [8:0]          r_x;
   logic [7:0]          r_y;
   logic [COLOUR_W-1:0] r_colour;
   logic                r_plot;

   logic                w_last;
   logic [9:0]          w_sx;
   logic [8:0]          w_sy;
   logic                w_on_screen;
   logic                w_key_hit;

   // The last address of the image is (WIDTH-1, HEIGHT-1).
   assign w_last = (r_col == 9'(WIDTH - 1)) && (r_row == 8'(HEIGHT - 1));

   // Screen coordinates are one bit wider than the outputs so that
   // overflow past the screen edge is visible to the clip test.
   assign w_sx = {1'b0, r_x_org} + {1'b0, r_pcol[LAST]};
   assign w_sy = {1'b0, r_y_org} + {1'b0, r_prow[LAST]};
   assign w_on_screen = (w_sx < 10'(SCREEN_W)) && (w_sy < 9'(SCREEN_H));

`ifdef SPRITE_TRANSPARENT_EN
   assign w_key_hit = (rom_q == TRANSPARENT);
`else
   // Colour keying is disabled in this build: the compare is masked off.
   assign w_key_hit = 1'b0 & (rom_q == TRANSPARENT);
`endif

   // Control FSM: accepts start, walks the image addresses, drains the pipeline.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_col         <= '0;
         r_row         <= '0;
         r_rom_address <= '0;
         r_x_org       <= '0;
         r_y_org       <= '0;
         r_drain_cnt   <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x_org       <= x_origin;
                  r_y_org       <= y_origin;
                  r_col         <= '0;
                  r_row         <= '0;
                  r_rom_address <= '0;
                  r_busy        <= 1'b1;
                  r_state       <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (w_last) begin
                  r_drain_cnt <= '0;
                  r_state     <= S_DRAIN;
               end else begin
                  // Linear address tracks row*WIDTH+col by counting.
                  r_rom_address <= r_rom_address + ADDR_W'(1);
                  if (r_col == 9'(WIDTH - 1)) begin
                     r_col <= '0;
                     r_row <= r_row + 8'd1;
                  end else begin
                     r_col <= r_col + 9'd1;
                  end
               end
            end
            S_DRAIN: begin
               // ROM_LATENCY+1 cycles: ROM stages plus the output register.
               if (r_drain_cnt == 2'(ROM_LATENCY)) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 2'd1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Delay the fetched coordinates so they meet their ROM data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pv <= '0;
         for (int i = 0; i < ROM_LATENCY; i++) begin
            r_pcol[i] <= '0;
            r_prow[i] <= '0;
         end
      end else begin
         r_pv[0]   <= (r_state == S_FETCH);
         r_pcol[0] <= r_col;
         r_prow[0] <= r_row;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            r_pv[i]   <= r_pv[i-1];
            r_pcol[i] <= r_pcol[i-1];
            r_prow[i] <= r_prow[i-1];
         end
      end
   end

   // Register the pixel: position, colour and clip/transparency-gated plot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
         r_plot   <= 1'b0;
      end else begin
         if (r_pv[LAST]) begin
            r_x      <= w_sx[8:0];
            r_y      <= w_sy[7:0];
            r_colour <= rom_q;
            r_plot   <= w_on_screen && !w_key_hit;
         end else begin
            r_plot   <= 1'b0;
         end
      end
   end

   assign rom_address = r_rom_address;
   assign x           = r_x;
   assign y           = r_y;
   assign colour      = r_colour;
   assign plot        = r_plot;
   assign busy        = r_busy;
   assign done        = r_done;
   assign dbg_state   = r_state;

endmodule
